// File: rtl/ysyx_22040125_operand_fetch.sv
// Operand fetch: reads the register file, forwards writeback data, stalls on RAW/WAW via a busy scoreboard.
// Accept-to-out_valid latency is 1 cycle; in_ready drops on hazard, flush, or a held bundle execute has not taken.
module ysyx_22040125_operand_fetch #(
  parameter int PAYLOAD_W = 32,
  parameter int XLEN      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_rd_wen,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_addr_rs1,
  output logic [4:0]           rf_addr_rs2,
  input  logic [XLEN-1:0]      rf_data_rs1,
  input  logic [XLEN-1:0]      rf_data_rs2,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [4:0]           out_rd,
  output logic                 out_rd_wen,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [31:0]          busy_q, busy_d;
  logic                 out_valid_q;
  logic [XLEN-1:0]      rs1_val_q, rs2_val_q;
  logic [4:0]           rd_q;
  logic                 rd_wen_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 hazard;
  logic                 accept;

  function automatic logic wb_hit(input logic [4:0] r);
    return wb_en && (wb_addr == r) && (r != 5'd0);
  endfunction

  // A writeback landing this cycle satisfies the dependency through forwarding.
  function automatic logic eff_busy(input logic [4:0] r);
    return busy_q[r] && !wb_hit(r);
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] r, input logic [XLEN-1:0] rf);
    if (r == 5'd0)  return '0;
    if (wb_hit(r))  return wb_data;
    return rf;
  endfunction

  assign rf_addr_rs1 = in_rs1;
  assign rf_addr_rs2 = in_rs2;

  assign hazard = (in_use_rs1 && eff_busy(in_rs1)) ||
                  (in_use_rs2 && eff_busy(in_rs2)) ||
                  (in_rd_wen  && eff_busy(in_rd));

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Ordering gives set priority over writeback clear, and flush clear priority over set.
  always_comb begin
    busy_d = busy_q;
    if (wb_en && wb_addr != 5'd0)
      busy_d[wb_addr] = 1'b0;
    if (accept && in_rd_wen && in_rd != 5'd0)
      busy_d[in_rd] = 1'b1;
    if (flush && out_valid_q && rd_wen_q && rd_q != 5'd0)
      busy_d[rd_q] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      payload_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        rs1_val_q   <= operand(in_rs1, rf_data_rs1);
        rs2_val_q   <= operand(in_rs2, rf_data_rs2);
        rd_q        <= in_rd;
        rd_wen_q    <= in_rd_wen;
        payload_q   <= in_payload;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_rd      = rd_q;
  assign out_rd_wen  = rd_wen_q;
  assign out_payload = payload_q;

endmodule

// File: tb/tb_ysyx_22040125_operand_fetch.sv
// Directed bench for the operand fetch stage; busy bits are observed through in_ready probes.
module tb_ysyx_22040125_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_wen;
  logic [31:0] in_payload;
  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [63:0] rf_data_rs1, rf_data_rs2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_payload;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040125_operand_fetch #(.PAYLOAD_W(32), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_payload(in_payload),
    .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
    .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_payload(out_payload)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = 0; in_rd_wen = 0; in_payload = 0;
    rf_data_rs1 = 0; rf_data_rs2 = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic [31:0] pl);
    in_valid = 1; in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_rd_wen = wen; in_payload = pl;
  endtask

  // Combinational look at busy[r]: a pure rs1 reader is ready exactly when r is not busy.
  task automatic probe_busy(input string tag, input logic [4:0] r, input logic exp_busy);
    in_valid = 0; in_use_rs1 = 1; in_rs1 = r; in_use_rs2 = 0; in_rd_wen = 0;
    wb_en = 0; flush = 0; out_ready = 1;
    #1;
    check(tag, {63'd0, in_ready}, {63'd0, !exp_busy});
  endtask

  initial begin
    idle();
    rst_n = 0;
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 32'hFFFF_0000);
    rf_data_rs1 = 64'h55;
    step(); step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_rs1_val", out_rs1_val, 64'd0);
    check("rst_rs2_val", out_rs2_val, 64'd0);
    check("rst_rd", {59'd0, out_rd}, 64'd0);
    check("rst_rd_wen", {63'd0, out_rd_wen}, 64'd0);
    check("rst_payload", {32'd0, out_payload}, 64'd0);
    rst_n = 1;
    probe_busy("rst_busy3", 5'd3, 0);

    // Independent add
    idle();
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 32'hA5A5_0001);
    rf_data_rs1 = 64'h11; rf_data_rs2 = 64'h22;
    check("add_rf_addr1", {59'd0, rf_addr_rs1}, 64'd1);
    check("add_rf_addr2", {59'd0, rf_addr_rs2}, 64'd2);
    @(negedge clk);
    check("add_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("add_out_valid", {63'd0, out_valid}, 64'd1);
    check("add_rs1", out_rs1_val, 64'h11);
    check("add_rs2", out_rs2_val, 64'h22);
    check("add_rd", {59'd0, out_rd}, 64'd3);
    check("add_rd_wen", {63'd0, out_rd_wen}, 64'd1);
    check("add_payload", {32'd0, out_payload}, 64'hA5A5_0001);
    probe_busy("add_busy3", 5'd3, 1);
    step();
    check("add_drain", {63'd0, out_valid}, 64'd0);

    // RAW stall on x3, released by a same-cycle writeback
    idle();
    issue(5'd3, 1, 5'd0, 0, 5'd4, 1, 32'h0000_0002);
    rf_data_rs1 = 64'h999;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("raw_stall_ready", {63'd0, in_ready}, 64'd0);
      step();
      check("raw_stall_valid", {63'd0, out_valid}, 64'd0);
    end
    wb_en = 1; wb_addr = 5'd3; wb_data = 64'hDEAD_BEEF;
    @(negedge clk);
    check("raw_wb_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("raw_out_valid", {63'd0, out_valid}, 64'd1);
    check("raw_fwd_rs1", out_rs1_val, 64'hDEAD_BEEF);
    check("raw_rd", {59'd0, out_rd}, 64'd4);
    probe_busy("raw_busy3", 5'd3, 0);
    probe_busy("raw_busy4", 5'd4, 1);
    idle();
    wb_en = 1; wb_addr = 5'd4;
    step();
    idle();
    probe_busy("raw_busy4_clr", 5'd4, 0);
    step();

    // x0 handling
    idle();
    issue(5'd0, 1, 5'd0, 1, 5'd0, 1, 32'h0000_0003);
    rf_data_rs1 = 64'hFFFF; rf_data_rs2 = 64'hABCD;
    wb_en = 1; wb_addr = 5'd0; wb_data = 64'h1234;
    @(negedge clk);
    check("x0_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("x0_rs1", out_rs1_val, 64'd0);
    check("x0_rs2", out_rs2_val, 64'd0);
    check("x0_valid", {63'd0, out_valid}, 64'd1);
    probe_busy("x0_busy0", 5'd0, 0);
    step();

    // Backpressure and back-to-back throughput
    idle();
    issue(5'd1, 1, 5'd2, 1, 5'd0, 0, 32'hB000_0001);
    rf_data_rs1 = 64'h100; rf_data_rs2 = 64'h200;
    step();
    check("bp_a_rs1", out_rs1_val, 64'h100);
    issue(5'd5, 1, 5'd6, 1, 5'd0, 0, 32'hB000_0002);
    rf_data_rs1 = 64'h500; rf_data_rs2 = 64'h600;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp_hold_rs1", out_rs1_val, 64'h100);
      check("bp_hold_rs2", out_rs2_val, 64'h200);
      check("bp_hold_payload", {32'd0, out_payload}, 64'hB000_0001);
    end
    out_ready = 1;
    @(negedge clk);
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_b_valid", {63'd0, out_valid}, 64'd1);
    check("bp_b_rs1", out_rs1_val, 64'h500);
    check("bp_b_payload", {32'd0, out_payload}, 64'hB000_0002);
    issue(5'd7, 1, 5'd8, 1, 5'd0, 0, 32'hB000_0003);
    rf_data_rs1 = 64'h700; rf_data_rs2 = 64'h1;
    wb_en = 1; wb_addr = 5'd8; wb_data = 64'h888;
    @(negedge clk);
    check("b2b_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    check("b2b_rs1", out_rs1_val, 64'h700);
    check("b2b_fwd_rs2", out_rs2_val, 64'h888);
    check("b2b_payload", {32'd0, out_payload}, 64'hB000_0003);
    idle();
    step();

    // WAW stall and same-cycle set/clear on x5
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 32'hC000_0001);
    step();
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1, 32'hC000_0002);
    @(negedge clk);
    check("waw_stall", {63'd0, in_ready}, 64'd0);
    step();
    wb_en = 1; wb_addr = 5'd5; wb_data = 64'h5;
    @(negedge clk);
    check("waw_wb_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("waw_payload", {32'd0, out_payload}, 64'hC000_0002);
    probe_busy("waw_busy5_kept", 5'd5, 1);
    idle();
    wb_en = 1; wb_addr = 5'd5;
    step();
    idle();
    step();

    // Flush of a held bundle writing x7
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 32'hD000_0001);
    step();
    check("fl_valid", {63'd0, out_valid}, 64'd1);
    check("fl_rd", {59'd0, out_rd}, 64'd7);
    issue(5'd1, 1, 5'd0, 0, 5'd0, 0, 32'hD000_0002);
    out_ready = 0; flush = 1;
    @(negedge clk);
    check("fl_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    probe_busy("fl_busy7", 5'd7, 0);
    idle();
    step();

    // Reset during a RAW stall
    issue(5'd0, 0, 5'd0, 0, 5'd9, 1, 32'hE000_0001);
    step();
    issue(5'd9, 1, 5'd0, 0, 5'd0, 0, 32'hE000_0002);
    out_ready = 0;
    @(negedge clk);
    check("rs_stall", {63'd0, in_ready}, 64'd0);
    step();
    rst_n = 0;
    step();
    check("rs_out_valid", {63'd0, out_valid}, 64'd0);
    check("rs_payload", {32'd0, out_payload}, 64'd0);
    check("rs_rd", {59'd0, out_rd}, 64'd0);
    rst_n = 1;
    idle();
    probe_busy("rs_busy9", 5'd9, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_operand_fetch.md
Name: ysyx_22040125_operand_fetch

Overview:
Operand-fetch stage that sits between decode and execute and initiates reads into the 32x64 integer register file.
- Presents rs1/rs2 addresses to the register file and captures the returned data.
- Tracks in-flight destination registers with a busy scoreboard.
- Forwards same-cycle writeback data and stalls on RAW/WAW hazards.
- Hands a registered operand bundle downstream over a valid/ready handshake.

Parameters:
PAYLOAD_W, 32, width of opaque decode payload (opcode/imm/pc bits) carried alongside operands
XLEN, 64, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_rs1  in  5  source 1 index
in_rs2  in  5  source 2 index
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_rd  in  5  destination index
in_rd_wen  in  1  instruction writes rd
in_payload  in  PAYLOAD_W  passthrough payload
rf_addr_rs1  out  5  register file read address 1, equal to in_rs1, combinational
rf_addr_rs2  out  5  register file read address 2, equal to in_rs2, combinational
rf_data_rs1  in  XLEN  register file read data 1, combinational response
rf_data_rs2  in  XLEN  register file read data 2, combinational response
wb_en  in  1  writeback this cycle; the same signals drive the register file write port
wb_addr  in  5  writeback index
wb_data  in  XLEN  writeback data
flush  in  1  squash the held output instruction and block acceptance this cycle
out_valid  out  1  operand bundle valid
out_ready  in  1  execute consumes the bundle
out_rs1_val  out  XLEN  rs1 operand
out_rs2_val  out  XLEN  rs2 operand
out_rd  out  5  destination index
out_rd_wen  out  1  destination write enable
out_payload  out  PAYLOAD_W  payload

Behaviour:
- Reset (rst_n=0 at an edge): busy[31:0]=0, out_valid=0; out_rs1_val, out_rs2_val, out_rd, out_rd_wen and out_payload all =0. Reset overrides all other inputs, including mid-stall.
- Register x0: never busy. Operand value is always 0 regardless of rf data or wb_data. in_rd=0 never sets a busy bit.
- wb_hit(r): wb_en && wb_addr==r && r!=0.
- eff_busy(r): busy[r] && !wb_hit(r).
- hazard, true when any of the following holds:
  - in_use_rs1 && eff_busy(in_rs1)
  - in_use_rs2 && eff_busy(in_rs2)
  - in_rd_wen && eff_busy(in_rd). This is a WAW stall, so at most one in-flight writer exists per register.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational, with no dependency on in_valid.
- accept = in_valid && in_ready. On accept, next edge:
  - out_valid=1.
  - Each operand = 0 if its index is 0; else wb_data if wb_hit(index); else rf data.
  - Unused operands are captured the same way; their value is don't-care.
  - out_rd, out_rd_wen and out_payload are captured from the inputs.
  - Latency from accept to out_valid is 1 cycle.
- Without accept: if out_valid && out_ready, out_valid<=0. Otherwise the output holds all fields stable (no change while out_valid && !out_ready).
- Scoreboard update, each edge:
  - A wb_hit clears busy[wb_addr].
  - An accept with in_rd_wen && in_rd!=0 sets busy[in_rd].
  - If the set and clear target the same register in the same cycle, the set wins.
- Busy bits stay set after the bundle leaves this stage; only a writeback clears them.
- flush:
  - Forces in_ready=0.
  - Next edge: out_valid=0.
  - If the held bundle was valid with out_rd_wen && out_rd!=0, busy[out_rd] is cleared. This flush clear also wins over a set in the same cycle, which cannot occur because in_ready=0.
  - Busy bits of bundles already consumed downstream are unaffected; those writers must still write back.
- The writeback path has priority only through forwarding. Register file write timing is external; its data is visible to rf_data the cycle after wb_en.

Test Plan:
- Reset then independent add: in_rs1=1, in_rs2=2, rf data 0x11/0x22, in_rd=3, out_ready=1 -> next cycle out_valid=1, operands 0x11/0x22, busy[3]=1.
- RAW stall: busy[3]=1, in_use_rs1 with in_rs1=3 -> in_ready=0 for 4 cycles. Then wb_en, wb_addr=3, wb_data=0xDEADBEEF -> accept that same cycle, out_rs1_val=0xDEADBEEF, busy[3]=0 (set again only if the instruction also writes x3).
- x0 handling: in_rs1=0 with rf_data_rs1=0xFFFF, wb_en, wb_addr=0 -> out_rs1_val=0, no stall. in_rd=0 with in_rd_wen=1 -> busy unchanged.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and a new in_valid -> in_ready=0 and outputs stable. out_ready=1 -> new bundle appears next cycle, back-to-back throughput of 1 per cycle.
- WAW plus same-cycle set/clear: busy[5]=1, new instruction in_rd=5, wb_hit(5) same cycle -> accept, busy[5] remains 1.
- Flush: out_valid=1, out_rd=7, busy[7]=1, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0 and busy[7]=0. rst_n=0 during a stall -> next cycle out_valid=0 and all busy bits 0.
